// File: rtl/r4_sdf_input_gather_pkg.sv
// Shared radix-4 SDF FFT definitions: complex sample type and constant helpers.
package r4_sdf_input_gather_pkg;

    localparam int unsigned FFT_WIDTH = 32;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/r4_sdf_bank_ram.sv
// Simple dual-port memory: one synchronous write port, one asynchronous read port.
module r4_sdf_bank_ram
    import r4_sdf_input_gather_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ADDRW = 4,
    parameter int unsigned DATAW = 2 * FFT_WIDTH
) (
    input  logic             clock,
    input  logic             wr_en_i,
    input  logic [ADDRW-1:0] wr_addr_i,
    input  logic [DATAW-1:0] wr_data_i,
    input  logic [ADDRW-1:0] rd_addr_i,
    output logic [DATAW-1:0] rd_data_c
);

    logic [DATAW-1:0] mem_q [DEPTH];

    // No reset on the array so it maps onto distributed/block RAM.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/r4_sdf_input_gather.sv
// Gathers x[n], x[n+D], x[n+2D], x[n+3D] from a serial stream for the radix-4 butterfly.
module r4_sdf_input_gather
    import r4_sdf_input_gather_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned DELAY = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic signed [WIDTH-1:0]       in_r,
    input  logic signed [WIDTH-1:0]       in_i,
    output logic                          start,
    output logic signed [WIDTH-1:0]       ar,
    output logic signed [WIDTH-1:0]       ai,
    output logic signed [WIDTH-1:0]       br,
    output logic signed [WIDTH-1:0]       bi,
    output logic signed [WIDTH-1:0]       cr,
    output logic signed [WIDTH-1:0]       ci,
    output logic signed [WIDTH-1:0]       dr,
    output logic signed [WIDTH-1:0]       di,
    output logic [clog2(DELAY)-1:0]       tw_idx,
    output logic                          grp_last,
    output logic                          sof_err
);

    localparam int unsigned IDXW  = clog2(DELAY);
    localparam int unsigned CNTW  = IDXW + 2;
    localparam int unsigned WORDW = 2 * WIDTH;

    logic [CNTW-1:0]  cnt_q, cnt_d, cnt_eff;
    logic [1:0]       quarter;
    logic [IDXW-1:0]  idx;
    logic [WORDW-1:0] sample;
    logic             out_fire;
    logic [WORDW-1:0] rd_data [3];

    logic             start_q, start_d;
    logic             grp_last_q, grp_last_d;
    logic             sof_err_q, sof_err_d;
    logic [IDXW-1:0]  tw_idx_q, tw_idx_d;
    logic [WORDW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

    // A start-of-frame sample is always position 0, whatever the counter held.
    assign cnt_eff  = in_sof ? '0 : cnt_q;
    assign quarter  = cnt_eff[CNTW-1 -: 2];
    assign idx      = cnt_eff[IDXW-1:0];
    assign sample   = {in_r, in_i};
    assign out_fire = in_valid && (quarter == 2'd3);

    for (genvar k = 0; k < 3; k++) begin : g_bank
        r4_sdf_bank_ram #(
            .DEPTH (DELAY),
            .ADDRW (IDXW),
            .DATAW (WORDW)
        ) u_bank (
            .clock     (clock),
            .wr_en_i   (in_valid && (quarter == 2'(k))),
            .wr_addr_i (idx),
            .wr_data_i (sample),
            .rd_addr_i (idx),
            .rd_data_c (rd_data[k])
        );
    end

    // Next-state for counter, error flag and output register.
    always_comb begin
        cnt_d      = cnt_q;
        sof_err_d  = sof_err_q;
        start_d    = out_fire;
        grp_last_d = out_fire && (idx == IDXW'(DELAY - 1));
        tw_idx_d   = tw_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        if (in_valid) begin
            cnt_d = cnt_eff + CNTW'(1);
            if (in_sof && (cnt_q != '0)) begin
                sof_err_d = 1'b1;
            end
        end
        if (out_fire) begin
            tw_idx_d = idx;
            a_d      = rd_data[0];
            b_d      = rd_data[1];
            c_d      = rd_data[2];
            d_d      = sample;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            sof_err_q  <= 1'b0;
            start_q    <= 1'b0;
            grp_last_q <= 1'b0;
            tw_idx_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sof_err_q  <= sof_err_d;
            start_q    <= start_d;
            grp_last_q <= grp_last_d;
            tw_idx_q   <= tw_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
        end
    end

    assign start    = start_q;
    assign grp_last = grp_last_q;
    assign sof_err  = sof_err_q;
    assign tw_idx   = tw_idx_q;
    assign ar       = a_q[WORDW-1:WIDTH];
    assign ai       = a_q[WIDTH-1:0];
    assign br       = b_q[WORDW-1:WIDTH];
    assign bi       = b_q[WIDTH-1:0];
    assign cr       = c_q[WORDW-1:WIDTH];
    assign ci       = c_q[WIDTH-1:0];
    assign dr       = d_q[WORDW-1:WIDTH];
    assign di       = d_q[WIDTH-1:0];

endmodule
